// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and default width.
package serial_subtractor_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_subtractor_cell.sv
// 1-bit full-subtractor cell: diff = a - b - bin, bout set when the result borrows.
module serial_subtractor_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first, through a single
// full-subtractor cell with the borrow fed back through a register.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] diff_sr_q, diff_sr_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             bout_q, bout_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cell_diff, cell_bout;
   logic [WIDTH-1:0] diff_shift;

   serial_subtractor_cell u_cell (
      .a    (a_sr_q[0]),
      .b    (b_sr_q[0]),
      .bin  (borrow_q),
      .diff (cell_diff),
      .bout (cell_bout)
   );

   // Cell output enters at the MSB so bit i settles at position i after WIDTH shifts.
   assign diff_shift = {cell_diff, diff_sr_q[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN:  if (cnt_q == CNT_LAST) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == ST_RUN);
      done = (state_q == ST_DONE);
   end

   always_comb begin
      a_sr_d    = a_sr_q;
      b_sr_d    = b_sr_q;
      diff_sr_d = diff_sr_q;
      diff_d    = diff_q;
      borrow_d  = borrow_q;
      bout_d    = bout_q;
      cnt_d     = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_sr_d    = a;
               b_sr_d    = b;
               diff_sr_d = '0;
               borrow_d  = 1'b0;
               cnt_d     = '0;
            end
         end
         ST_RUN: begin
            a_sr_d    = a_sr_q >> 1;
            b_sr_d    = b_sr_q >> 1;
            diff_sr_d = diff_shift;
            borrow_d  = cell_bout;
            // Counter parks on the last index instead of wrapping.
            if (cnt_q == CNT_LAST) begin
               diff_d = diff_shift;
               bout_d = cell_bout;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr_q    <= '0;
         b_sr_q    <= '0;
         diff_sr_q <= '0;
         diff_q    <= '0;
         borrow_q  <= 1'b0;
         bout_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         a_sr_q    <= a_sr_d;
         b_sr_q    <= b_sr_d;
         diff_sr_q <= diff_sr_d;
         diff_q    <= diff_d;
         borrow_q  <= borrow_d;
         bout_q    <= bout_d;
         cnt_q     <= cnt_d;
      end
   end

   assign diff = diff_q;
   assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): latency, results, ignore and reset behaviour.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a, b, diff;
   logic         busy, done, bout;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
   );

   // Starts an operation and waits for done. Cycle t=0 is the cycle after the accepting edge.
   // If inj >= 0, a start with operands 1/1 is pulsed during cycle inj.
   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input int inj,
                         output int lat, output int busy_n, output logic [W-1:0] d,
                         output logic bo, output logic [W-1:0] d_run);
      @(negedge clk);
      start = 1'b1; a = av; b = bv;
      @(negedge clk);
      start = 1'b0; a = ~av; b = ~bv;
      lat = -1; busy_n = 0; d = 'x; bo = 1'bx; d_run = diff;
      for (int t = 0; t < 40; t++) begin
         if (busy) busy_n++;
         if (done) begin
            lat = t; d = diff; bo = bout;
            break;
         end
         if (t == inj) begin
            start = 1'b1; a = 8'd1; b = 8'd1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      total++; if (diff !== 8'd0) begin bad++; $display("FAIL reset_diff got=%0d want=0", diff); end
      total++; if (bout !== 1'b0) begin bad++; $display("FAIL reset_bout got=%b want=0", bout); end
   endtask

   task automatic test_basic();
      int lat, bn; logic [W-1:0] d, dr; logic bo;
      run_op(8'd100, 8'd37, -1, lat, bn, d, bo, dr);
      total++; if (lat !== 8) begin bad++; $display("FAIL basic_latency got=%0d want=8", lat); end
      total++; if (bn !== 8) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=8", bn); end
      total++; if (d !== 8'd63) begin bad++; $display("FAIL basic_diff got=%0d want=63", d); end
      total++; if (bo !== 1'b0) begin bad++; $display("FAIL basic_bout got=%b want=0", bo); end
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_width got=%b want=0", done); end
      repeat (3) @(negedge clk);
      total++; if (diff !== 8'd63) begin bad++; $display("FAIL basic_hold got=%0d want=63", diff); end
   endtask

   task automatic test_vectors();
      logic [W-1:0] va [3] = '{8'd5, 8'd0, 8'hA5};
      logic [W-1:0] vb [3] = '{8'd9, 8'd1, 8'hA5};
      logic [W-1:0] vd [3] = '{8'hFC, 8'hFF, 8'h00};
      logic         vo [3] = '{1'b1, 1'b1, 1'b0};
      logic [W-1:0] prev = 8'd63;
      int lat, bn; logic [W-1:0] d, dr; logic bo;
      for (int i = 0; i < 3; i++) begin
         run_op(va[i], vb[i], -1, lat, bn, d, bo, dr);
         total++; if (dr !== prev) begin bad++; $display("FAIL vec%0d_hold_in_run got=%h want=%h", i, dr, prev); end
         total++; if (d !== vd[i]) begin bad++; $display("FAIL vec%0d_diff got=%h want=%h", i, d, vd[i]); end
         total++; if (bo !== vo[i]) begin bad++; $display("FAIL vec%0d_bout got=%b want=%b", i, bo, vo[i]); end
         prev = vd[i];
         repeat (2) @(negedge clk);
      end
      run_op(8'd0, 8'hFF, -1, lat, bn, d, bo, dr);
      total++; if (d !== 8'd1) begin bad++; $display("FAIL min_minus_max_diff got=%h want=01", d); end
      total++; if (bo !== 1'b1) begin bad++; $display("FAIL min_minus_max_bout got=%b want=1", bo); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_ignore_start();
      int lat, bn; logic [W-1:0] d, dr; logic bo;
      run_op(8'd200, 8'd55, 3, lat, bn, d, bo, dr);
      total++; if (lat !== 8) begin bad++; $display("FAIL ignore_latency got=%0d want=8", lat); end
      total++; if (d !== 8'd145) begin bad++; $display("FAIL ignore_diff got=%0d want=145", d); end
      total++; if (bo !== 1'b0) begin bad++; $display("FAIL ignore_bout got=%b want=0", bo); end
      @(negedge clk);
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_not_queued got=%b want=0", busy); end
   endtask

   task automatic test_reset_mid_run();
      int lat, bn, seen; logic [W-1:0] d, dr; logic bo;
      @(negedge clk);
      start = 1'b1; a = 8'd50; b = 8'd20;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
      total++; if (diff !== 8'd0) begin bad++; $display("FAIL midrst_diff got=%0d want=0", diff); end
      seen = 0;
      for (int t = 0; t < 15; t++) begin
         if (done) seen++;
         @(negedge clk);
      end
      total++; if (seen !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d want=0", seen); end
      run_op(8'd10, 8'd3, -1, lat, bn, d, bo, dr);
      total++; if (d !== 8'd7) begin bad++; $display("FAIL midrst_after_diff got=%0d want=7", d); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int times [3];
      int n = 0;
      @(negedge clk);
      start = 1'b1; a = 8'h80; b = 8'h01;
      @(negedge clk);
      for (int t = 0; t < 60; t++) begin
         if (done) begin
            times[n] = t;
            total++; if (diff !== 8'h7F) begin bad++; $display("FAIL b2b%0d_diff got=%h want=7f", n, diff); end
            total++; if (bout !== 1'b0) begin bad++; $display("FAIL b2b%0d_bout got=%b want=0", n, bout); end
            n++;
            if (n == 3) break;
         end
         @(negedge clk);
      end
      start = 1'b0;
      total++; if (n !== 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", n); end
      if (n == 3) begin
         total++; if (times[0] !== 8) begin bad++; $display("FAIL b2b_first got=%0d want=8", times[0]); end
         total++; if (times[1] - times[0] !== 10) begin bad++; $display("FAIL b2b_period1 got=%0d want=10", times[1] - times[0]); end
         total++; if (times[2] - times[1] !== 10) begin bad++; $display("FAIL b2b_period2 got=%0d want=10", times[2] - times[1]); end
      end
      repeat (3) @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_after got=%b want=0", busy); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_vectors();
      test_ignore_start();
      test_reset_mid_run();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
